mem_subsystem_arb: RTL and testbench
====================================

Name: mem_subsystem_arb

Overview:
- Unified single-port word memory shared by the processor's instruction-fetch port and data port.
- Successor to the separate fixed imem/dmem pair: parametrised width, depth and read latency.
- Adds round-robin arbitration, a valid/ready request handshake and a pipelined read response, so the core can stall on contention.
- Sits between the processor and its memory at system top level.

Parameters:
- DATA_W, 32, data word width in bits.
- INSTR_W, 24, instruction width returned on the fetch port (low INSTR_W bits of the stored word); must be <= DATA_W.
- DEPTH_LOG2, 8, log2 of the number of words.
- RD_LAT, 1, read latency in cycles from accept to rvalid; legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- i_req  in  1  fetch request valid.
- i_addr  in  32  fetch byte address.
- i_ready  out  1  fetch request accepted this cycle.
- i_rvalid  out  1  fetch read data valid.
- i_rdata  out  INSTR_W  fetched instruction.
- d_req  in  1  data request valid.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  32  data byte address.
- d_wdata  in  DATA_W  write data.
- d_ready  out  1  data request accepted this cycle.
- d_rvalid  out  1  data read data valid (reads only).
- d_rdata  out  DATA_W  data read result.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Addressing:
  - Word index = addr[DEPTH_LOG2+1:2].
  - addr[1:0] ignored; upper bits ignored, so addresses alias modulo 4*2^DEPTH_LOG2.
- Acceptance:
  - A request is accepted when req && ready in the same cycle.
  - At most one accept per cycle across both ports.
  - ready is combinational from req and the arbiter state.
  - A requester must hold req, addr, we and wdata stable until ready.
- Arbitration:
  - Only one port requesting: it is granted.
  - Both requesting: round-robin. Grant the port opposite to last_grant; last_grant updates on every accept.
  - last_grant resets to "data", so the first contested grant goes to fetch.
  - No starvation: with both ports held high, grants strictly alternate.
- Writes:
  - Memory updates at the accept clock edge.
  - No response is generated (d_rvalid stays 0 for writes).
- Reads:
  - The memory array is read at accept.
  - The result travels through an RD_LAT-deep response pipeline carrying {valid, port, data}.
  - rvalid asserts on the matching port exactly RD_LAT cycles after the accept edge, for one cycle.
  - Back-to-back reads return back-to-back in acceptance order.
  - rdata holds its last value when rvalid = 0.
- Read-after-write: a read accepted in the cycle after a write to the same word returns the new data. A read and a write can never be accepted in the same cycle.
- Reset:
  - i_ready, d_ready, i_rvalid, d_rvalid = 0 while reset is high.
  - Response pipeline is cleared; i_rdata and d_rdata = 0; last_grant = data.
  - Memory contents are not cleared.
  - Reset mid-operation drops all in-flight reads: no rvalid is issued for them after reset deasserts.
- No flow control on responses: requesters must always accept rvalid.

Decomposition:
- Shared package mem_subsys_pkg holds:
  - constant RD_LAT_MAX = 4;
  - port-ID encoding PORT_I = 0, PORT_D = 1;
  - a response-stage record {valid, port, data}.
- Sub-module rr_arb2: 2-way round-robin arbiter with the last_grant register, req inputs and one-hot grant outputs.
- Memory array and response pipeline stay in the top of the block.

Test Plan:
1. Reset: hold reset 3 cycles with i_req = d_req = 1 -> both readys and rvalids = 0, rdata = 0. Release reset -> first accept goes to i.
2. Write then read, RD_LAT = 1: d write 0xDEADBEEF to 0x10, next cycle d read 0x10 -> d_rvalid 1 cycle after the read accept with d_rdata = 0xDEADBEEF. i_rvalid stays 0 throughout.
3. Contention: i_req and d_req held high for 6 cycles -> grant order i, d, i, d, i, d. Each read response appears on the correct port RD_LAT cycles after its grant.
4. Fetch width: store 0x12ABCDEF at 0x40, fetch 0x42 -> i_rdata = 0xABCDEF, since addr[1:0] is ignored and the result is truncated to INSTR_W.
5. Latency and aliasing, RD_LAT = 3, DEPTH_LOG2 = 8:
   - Write 0x55 to 0x400, read 0x000 -> returns 0x55 (alias).
   - Four consecutive reads -> four consecutive rvalid pulses, each starting 3 cycles after its accept, in order.
6. Reset mid-flight, RD_LAT = 3: accept a read, assert reset on the next cycle for 1 cycle -> no rvalid ever appears for that read. Memory still holds values written before the reset.

Source files
------------

// File: rtl/mem_subsys_pkg.sv
// Shared types and constants for the unified fetch/data memory subsystem.
package mem_subsys_pkg;

  // Deepest read pipeline the block is meant to be built with.
  localparam int RD_LAT_MAX  = 4;
  // Data field width of a response record; DATA_W must not exceed it.
  localparam int RESP_DATA_W = 64;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  // One slot of the read-response pipeline.
  typedef struct packed {
    logic                   valid;
    port_e                  port;
    logic [RESP_DATA_W-1:0] data;
  } resp_t;

endpackage

// File: rtl/mem_subsystem_arb_rr_arb2.sv
// Two-way round-robin arbiter; bit 0 = fetch port, bit 1 = data port.
module rr_arb2
  import mem_subsys_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  port_e last_grant;

  // Sole requester wins; on contention serve the port not served last.
  always_comb begin
    gnt = 2'b00;
    if (!reset) begin
      if (req == 2'b11) gnt = (last_grant == PORT_D) ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  // Every grant is an accept, so remember who was served most recently.
  always_ff @(posedge clk) begin
    if (reset)       last_grant <= PORT_D;
    else if (gnt[1]) last_grant <= PORT_D;
    else if (gnt[0]) last_grant <= PORT_I;
  end

endmodule

// File: rtl/mem_subsystem_arb.sv
// Single-port word memory shared by fetch and data ports, with round-robin
// arbitration and a fixed-latency pipelined read response.
module mem_subsystem_arb
  import mem_subsys_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int INSTR_W    = 24,
  parameter int DEPTH_LOG2 = 8,
  parameter int RD_LAT     = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_req,
  input  logic [31:0]        i_addr,
  output logic               i_ready,
  output logic               i_rvalid,
  output logic [INSTR_W-1:0] i_rdata,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [31:0]        d_addr,
  input  logic [DATA_W-1:0]  d_wdata,
  output logic               d_ready,
  output logic               d_rvalid,
  output logic [DATA_W-1:0]  d_rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [1:0]            gnt;
  logic [DEPTH_LOG2-1:0] i_idx, d_idx, rd_idx;
  logic                  acc_rd;
  logic [DATA_W-1:0]     mem [DEPTH];
  resp_t                 new_resp;
  resp_t                 stg_in [RD_LAT];
  resp_t                 pipe   [RD_LAT];
  resp_t                 last_in;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({d_req, i_req}),
    .gnt   (gnt)
  );

  assign i_ready = gnt[0];
  assign d_ready = gnt[1];

  // Byte address -> word index; low two bits and high bits are dropped.
  assign i_idx  = i_addr[DEPTH_LOG2+1:2];
  assign d_idx  = d_addr[DEPTH_LOG2+1:2];
  assign rd_idx = gnt[0] ? i_idx : d_idx;
  assign acc_rd = gnt[0] | (gnt[1] & ~d_we);

  // Stores land at the accept edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (gnt[1] && d_we) mem[d_idx] <= d_wdata;
  end

  // Sample the array at accept and wrap it as a fresh response record.
  always_comb begin
    new_resp       = '0;
    new_resp.valid = acc_rd;
    new_resp.port  = gnt[0] ? PORT_I : PORT_D;
    new_resp.data  = RESP_DATA_W'(mem[rd_idx]);
  end

  // Input of each pipe stage: the new record feeds stage 0, others shift.
  always_comb begin
    stg_in[0] = new_resp;
    for (int k = 1; k < RD_LAT; k++) stg_in[k] = pipe[k-1];
  end

  assign last_in = stg_in[RD_LAT-1];

  // Response pipe plus held read data; rdata loads with the last stage so
  // it is valid in the same cycle as rvalid and holds afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < RD_LAT; k++) pipe[k] <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      for (int k = 0; k < RD_LAT; k++) pipe[k] <= stg_in[k];
      if (last_in.valid) begin
        if (last_in.port == PORT_I) i_rdata <= last_in.data[INSTR_W-1:0];
        else                        d_rdata <= last_in.data[DATA_W-1:0];
      end
    end
  end

  // Responses are masked while reset is held.
  assign i_rvalid = !reset && pipe[RD_LAT-1].valid && (pipe[RD_LAT-1].port == PORT_I);
  assign d_rvalid = !reset && pipe[RD_LAT-1].valid && (pipe[RD_LAT-1].port == PORT_D);

endmodule

// File: tb/tb_mem_subsystem_arb.sv
// Bench: two instances (read latency 1 and 3) share one stimulus stream and
// are checked every cycle against a queue-based model of the memory.
module tb_mem_subsystem_arb;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;

  logic        i_ready1, i_rvalid1, d_ready1, d_rvalid1;
  logic [23:0] i_rdata1;
  logic [31:0] d_rdata1;
  logic        i_ready3, i_rvalid3, d_ready3, d_rvalid3;
  logic [23:0] i_rdata3;
  logic [31:0] d_rdata3;

  int nvec = 0, nbad = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  mem_subsystem_arb #(.RD_LAT(1)) u1 (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready1), .i_rvalid(i_rvalid1), .i_rdata(i_rdata1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1)
  );

  mem_subsystem_arb #(.RD_LAT(3)) u3 (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready3), .i_rvalid(i_rvalid3), .i_rdata(i_rdata3),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int          u;     // 0: latency-1 instance, 1: latency-3 instance
    int          due;
    bit          port;  // 0 fetch, 1 data
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  int          cyc = 0;
  bit          lg = 1;  // last served port, 1 = data
  logic [31:0] mm [256];
  logic [23:0] erd_i [2];
  logic [31:0] erd_d [2];

  logic        a_ir [2], a_dr [2], a_iv [2], a_dv [2];
  logic [23:0] a_id [2];
  logic [31:0] a_dd [2];
  assign a_ir[0] = i_ready1;  assign a_ir[1] = i_ready3;
  assign a_dr[0] = d_ready1;  assign a_dr[1] = d_ready3;
  assign a_iv[0] = i_rvalid1; assign a_iv[1] = i_rvalid3;
  assign a_dv[0] = d_rvalid1; assign a_dv[1] = d_rvalid3;
  assign a_id[0] = i_rdata1;  assign a_id[1] = i_rdata3;
  assign a_dd[0] = d_rdata1;  assign a_dd[1] = d_rdata3;

  always @(negedge clk) begin : model
    bit evi [2];
    bit evd [2];
    bit gi, gd;
    int idx;
    evi[0] = 0; evi[1] = 0; evd[0] = 0; evd[1] = 0;
    for (int k = q.size() - 1; k >= 0; k--) begin
      if (q[k].due == cyc) begin
        if (q[k].port) begin evd[q[k].u] = 1; erd_d[q[k].u] = q[k].data; end
        else           begin evi[q[k].u] = 1; erd_i[q[k].u] = q[k].data[23:0]; end
        q.delete(k);
      end
    end
    gi = 0; gd = 0;
    if (!reset) begin
      if (i_req && d_req) begin gi = lg; gd = !lg; end
      else begin gi = i_req; gd = d_req; end
    end
    if (chk_en) begin
      for (int u = 0; u < 2; u++) begin
        chk($sformatf("i_ready L%0d", u ? 3 : 1), a_ir[u], gi);
        chk($sformatf("d_ready L%0d", u ? 3 : 1), a_dr[u], gd);
        chk($sformatf("i_rvalid L%0d", u ? 3 : 1), a_iv[u], evi[u] && !reset);
        chk($sformatf("d_rvalid L%0d", u ? 3 : 1), a_dv[u], evd[u] && !reset);
        chk($sformatf("i_rdata L%0d", u ? 3 : 1), a_id[u], erd_i[u]);
        chk($sformatf("d_rdata L%0d", u ? 3 : 1), a_dd[u], erd_d[u]);
      end
    end
    if (reset) begin
      q.delete();
      lg = 1;
      for (int u = 0; u < 2; u++) begin erd_i[u] = '0; erd_d[u] = '0; end
    end else if (gd && d_we) begin
      mm[d_addr[9:2]] = d_wdata;
    end else if (gi || gd) begin
      idx = gi ? int'(i_addr[9:2]) : int'(d_addr[9:2]);
      for (int u = 0; u < 2; u++) q.push_back('{u, cyc + (u ? 3 : 1), gd, mm[idx]});
    end
    if (!reset && (gi || gd)) lg = gd;
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic pe(); @(posedge clk); #1; endtask
  task automatic ne(); @(negedge clk); endtask

  // Present one request and hold it until accepted (bounded).
  task automatic do_req(input bit dp, input bit we, input logic [31:0] a, input logic [31:0] wd);
    bit got = 0;
    if (dp) begin d_req = 1; d_we = we; d_addr = a; d_wdata = wd; end
    else    begin i_req = 1; i_addr = a; end
    for (int n = 0; n < 20 && !got; n++) begin
      ne();
      got = dp ? d_ready1 : i_ready1;
      pe();
    end
    if (!got) begin
      nvec++; nbad++;
      $display("FAIL accept_timeout: got no ready expected ready within 20 cycles");
    end
    i_req = 0; d_req = 0; d_we = 0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit ip, dpn;
    ip = 0; dpn = 0;
    pe(); pe();
    chk_en = 1;
    reset = 0;

    // Fill every word so all reads have a known value.
    for (int k = 0; k < 256; k++) do_req(1, 1, k * 4, $urandom);

    // Reset held with both ports requesting; first accept afterwards is fetch.
    reset = 1; i_req = 1; d_req = 1; d_we = 0; i_addr = 32'h20; d_addr = 32'h24;
    for (int k = 0; k < 3; k++) begin
      ne();
      chk("rst i_ready", i_ready1, 0); chk("rst d_ready", d_ready3, 0);
      chk("rst d_rvalid", d_rvalid1, 0);
      if (k > 0) chk("rst d_rdata", d_rdata3, 0);
      pe();
    end
    reset = 0;
    ne(); chk("first grant i", i_ready1, 1); chk("first grant not d", d_ready1, 0); pe();
    ne(); chk("second grant d", d_ready1, 1); pe();
    i_req = 0; d_req = 0;
    pe(); pe(); pe();

    // Write then read-after-write on the data port.
    do_req(1, 1, 32'h10, 32'hDEADBEEF);
    do_req(1, 0, 32'h10, 0);
    ne();
    chk("raw d_rvalid L1", d_rvalid1, 1); chk("raw d_rdata L1", d_rdata1, 32'hDEADBEEF);
    chk("raw i_rvalid L1", i_rvalid1, 0);
    ne(); ne();
    chk("raw d_rvalid L3", d_rvalid3, 1); chk("raw d_rdata L3", d_rdata3, 32'hDEADBEEF);
    pe(); pe(); pe();

    // Contention: grants alternate starting with fetch.
    i_req = 1; d_req = 1; d_we = 0; i_addr = 32'h44; d_addr = 32'h88;
    for (int k = 0; k < 6; k++) begin
      ne();
      chk($sformatf("rr i_ready #%0d", k), i_ready1, (k % 2) == 0);
      chk($sformatf("rr d_ready #%0d", k), d_ready3, (k % 2) == 1);
      pe();
    end
    i_req = 0; d_req = 0;
    pe(); pe(); pe();

    // Fetch width and byte-offset ignore.
    do_req(1, 1, 32'h40, 32'h12ABCDEF);
    do_req(0, 0, 32'h42, 0);
    ne(); chk("fetch i_rdata L1", i_rdata1, 24'hABCDEF); chk("fetch i_rvalid L1", i_rvalid1, 1);
    ne(); ne(); chk("fetch i_rdata L3", i_rdata3, 24'hABCDEF);
    pe(); pe(); pe();

    // Aliasing across the 1 KiB address window.
    do_req(1, 1, 32'h400, 32'h55);
    do_req(1, 0, 32'h000, 0);
    ne(); ne(); ne();
    chk("alias d_rvalid L3", d_rvalid3, 1); chk("alias d_rdata L3", d_rdata3, 32'h55);
    pe();

    // Four back-to-back reads -> four back-to-back responses, 3 cycles later.
    d_req = 1; d_we = 0;
    for (int k = 0; k < 4; k++) begin
      d_addr = 32'h100 + k * 4;
      ne();
      chk($sformatf("b2b d_ready #%0d", k), d_ready3, 1);
      chk($sformatf("b2b d_rvalid c%0d", k), d_rvalid3, k == 3);
      pe();
    end
    d_req = 0;
    for (int j = 4; j < 8; j++) begin
      ne(); chk($sformatf("b2b d_rvalid c%0d", j), d_rvalid3, j <= 6); pe();
    end
    pe(); pe();

    // Reset one cycle after a read accept drops that read; memory survives.
    do_req(1, 0, 32'h10, 0);
    reset = 1;
    pe();
    reset = 0;
    for (int k = 0; k < 5; k++) begin
      ne(); chk("dropped d_rvalid L3", d_rvalid3, 0); chk("dropped d_rvalid L1", d_rvalid1, 0); pe();
    end
    do_req(1, 0, 32'h10, 0);
    ne(); ne(); ne();
    chk("retained d_rdata L3", d_rdata3, 32'hDEADBEEF);
    pe();

    // Random traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      if (!ip && $urandom_range(0, 2) != 0) begin ip = 1; i_addr = $urandom; end
      if (!dpn && $urandom_range(0, 2) != 0) begin
        dpn = 1; d_addr = $urandom; d_we = $urandom_range(0, 1); d_wdata = $urandom;
      end
      i_req = ip; d_req = dpn;
      ne();
      if (i_ready1) ip = 0;
      if (d_ready1) dpn = 0;
      pe();
    end
    reset = 0; i_req = 0; d_req = 0;
    repeat (8) pe();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
